pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/pipe_mem_arb.sv | 75 +++++++
 rtl/pipe_ctrl.sv | 69 ++++++
 tb/tb_pipe_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared stall-bus constants and memory-arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int c_STALL_W = 6;

    localparam logic [c_STALL_W-1:0] c_STALL_MEM = 6'b011111;
    localparam logic [c_STALL_W-1:0] c_STALL_ID  = 6'b001111;
    localparam logic [c_STALL_W-1:0] c_STALL_IF  = 6'b000111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2
    } arb_state_e;

    function automatic logic [c_STALL_W-1:0] stall_level(
        input logic                 active,
        input logic [c_STALL_W-1:0] level
    );
        return active ? level : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mem_arb
// Description : Single-port memory arbiter between IF and MEM with fetch discard.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mem_arb
    import ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic mem_req,
    input  logic mc_done,
    input  logic flush,
    output logic mc_req,
    output logic mc_sel,
    output logic if_done,
    output logic mem_done
);

    arb_state_e r_state;
    arb_state_e w_state_next;
    logic       r_discard;
    logic       w_discard_next;
    logic       w_in_if;
    logic       w_in_mem;
    logic       w_if_pend;
    logic       w_mem_pend;
    arb_state_e w_arb_pick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_discard <= w_discard_next;
        end
    end

    always_comb begin
        w_in_if  = (r_state == ST_IF_BUSY);
        w_in_mem = (r_state == ST_MEM_BUSY);

        // A flush in the completing cycle already kills the returning fetch.
        if_done  = w_in_if && mc_done && !(r_discard || flush);
        mem_done = w_in_mem && mc_done;
        mc_req   = w_in_if || w_in_mem;
        mc_sel   = w_in_mem;

        // A requester that is being served this cycle no longer competes.
        w_mem_pend = mem_req && !mem_done;
        w_if_pend  = if_req && !if_done;

        w_arb_pick = ST_IDLE;
        if (w_mem_pend) begin
            w_arb_pick = ST_MEM_BUSY;
        end else if (w_if_pend) begin
            w_arb_pick = ST_IF_BUSY;
        end

        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     w_state_next = w_arb_pick;
            ST_IF_BUSY,
            ST_MEM_BUSY: if (mc_done) w_state_next = w_arb_pick;
            default:     w_state_next = ST_IDLE;
        endcase

        w_discard_next = w_in_if && !mc_done && (r_discard || flush);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline stall/flush controller with shared memory arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic                 mem_req,
    input  logic                 id_stallreq,
    input  logic                 ex_branch,
    input  logic                 mc_done,
    output logic                 mc_req,
    output logic                 mc_sel,
    output logic                 if_done,
    output logic                 mem_done,
    output logic                 flush,
    output logic [c_STALL_W-1:0] stall_sign,
    output logic [31:0]          stall_cnt
);

    logic        w_mem_lvl;
    logic        w_if_lvl;
    logic [31:0] r_stall_cnt;

    pipe_mem_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .mem_req  (mem_req),
        .mc_done  (mc_done),
        .flush    (flush),
        .mc_req   (mc_req),
        .mc_sel   (mc_sel),
        .if_done  (if_done),
        .mem_done (mem_done)
    );

    always_comb begin
        w_mem_lvl = mem_req && !mem_done;
        w_if_lvl  = if_req && !if_done;

        stall_sign = '0;
        if (rst) begin
            stall_sign = stall_level(w_mem_lvl,   c_STALL_MEM)
                       | stall_level(id_stallreq, c_STALL_ID)
                       | stall_level(w_if_lvl,    c_STALL_IF);
        end

        // Only the MEM level drives stall bit 4, so this avoids a loop through if_done.
        flush = rst && ex_branch && !w_mem_lvl;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stall_sign[0]) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Table-driven scoreboard bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic        mem_req;
    logic        id_stallreq;
    logic        ex_branch;
    logic        mc_done;
    logic        mc_req;
    logic        mc_sel;
    logic        if_done;
    logic        mem_done;
    logic        flush;
    logic [5:0]  stall_sign;
    logic [31:0] stall_cnt;

    pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .mem_req     (mem_req),
        .id_stallreq (id_stallreq),
        .ex_branch   (ex_branch),
        .mc_done     (mc_done),
        .mc_req      (mc_req),
        .mc_sel      (mc_sel),
        .if_done     (if_done),
        .mem_done    (mem_done),
        .flush       (flush),
        .stall_sign  (stall_sign),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // stim = {rst, if_req, mem_req, id_stallreq, ex_branch, mc_done}
    // ctl  = {mc_req, mc_sel, if_done, mem_done, flush}
    typedef struct packed {
        logic [5:0] stim;
        logic [4:0] ctl;
        logic [5:0] st;
    } vec_t;

    typedef struct {
        int          tag;
        logic [10:0] outs;
        logic [31:0] cnt;
    } exp_t;

    localparam int c_NVEC = 39;

    vec_t        vecs [c_NVEC];
    exp_t        sb [$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    logic [31:0] model_cnt = 32'd0;

    function automatic vec_t mk(input logic [5:0] stim, input logic [4:0] ctl, input logic [5:0] st);
        vec_t r;
        r.stim = stim;
        r.ctl  = ctl;
        r.st   = st;
        return r;
    endfunction

    task automatic drive(input vec_t v, input int tag);
        exp_t e;
        {rst, if_req, mem_req, id_stallreq, ex_branch, mc_done} = v.stim;
        e.tag  = tag;
        e.outs = {v.ctl, v.st};
        e.cnt  = v.stim[5] ? model_cnt : 32'd0;
        sb.push_back(e);
        if (!v.stim[5]) model_cnt = 32'd0;
        else            model_cnt = model_cnt + {31'd0, v.st[0]};
    endtask

    task automatic sample();
        exp_t        e;
        logic [10:0] act;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: output sampled with empty expectation queue");
            return;
        end
        e   = sb.pop_front();
        act = {mc_req, mc_sel, if_done, mem_done, flush, stall_sign};
        if (act !== e.outs) begin
            n_errors++;
            $display("FAIL outs[%0d]: got %b required %b (req,sel,ifd,memd,flush,stall)",
                     e.tag, act, e.outs);
        end
        n_checks++;
        if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL stall_cnt[%0d]: got %0d required %0d", e.tag, stall_cnt, e.cnt);
        end
    endtask

    task automatic step(input vec_t v, input int tag);
        @(negedge clk);
        drive(v, tag);
        #4;
        sample();
    endtask

    initial begin
        rst         = 1'b0;
        if_req      = 1'b0;
        mem_req     = 1'b0;
        id_stallreq = 1'b0;
        ex_branch   = 1'b0;
        mc_done     = 1'b0;

        // reset gating, then single fetch completing on the 4th cycle
        vecs[0]  = mk(6'b011010, 5'b00000, 6'h00);
        vecs[1]  = mk(6'b100000, 5'b00000, 6'h00);
        vecs[2]  = mk(6'b110000, 5'b00000, 6'h07);
        vecs[3]  = mk(6'b110000, 5'b10000, 6'h07);
        vecs[4]  = mk(6'b110000, 5'b10000, 6'h07);
        vecs[5]  = mk(6'b110001, 5'b10100, 6'h00);
        vecs[6]  = mk(6'b100000, 5'b00000, 6'h00);
        // MEM priority, then back-to-back fetch
        vecs[7]  = mk(6'b111000, 5'b00000, 6'h1F);
        vecs[8]  = mk(6'b111000, 5'b11000, 6'h1F);
        vecs[9]  = mk(6'b111001, 5'b11010, 6'h07);
        vecs[10] = mk(6'b110000, 5'b10000, 6'h07);
        vecs[11] = mk(6'b110001, 5'b10100, 6'h00);
        // load-use stall only
        vecs[12] = mk(6'b100100, 5'b00000, 6'h0F);
        vecs[13] = mk(6'b100100, 5'b00000, 6'h0F);
        vecs[14] = mk(6'b100000, 5'b00000, 6'h00);
        // flush mid-fetch discards the next completion
        vecs[15] = mk(6'b110000, 5'b00000, 6'h07);
        vecs[16] = mk(6'b110010, 5'b10001, 6'h07);
        vecs[17] = mk(6'b110000, 5'b10000, 6'h07);
        vecs[18] = mk(6'b110001, 5'b10000, 6'h07);
        vecs[19] = mk(6'b110001, 5'b10100, 6'h00);
        // flush coinciding with completion
        vecs[20] = mk(6'b110000, 5'b00000, 6'h07);
        vecs[21] = mk(6'b110011, 5'b10001, 6'h07);
        vecs[22] = mk(6'b110001, 5'b10100, 6'h00);
        // branch held off while MEM stalls EX; no discard from MEM-phase flush
        vecs[23] = mk(6'b101010, 5'b00000, 6'h1F);
        vecs[24] = mk(6'b101010, 5'b11000, 6'h1F);
        vecs[25] = mk(6'b101011, 5'b11011, 6'h00);
        vecs[26] = mk(6'b110000, 5'b00000, 6'h07);
        vecs[27] = mk(6'b110001, 5'b10100, 6'h00);
        // no preemption of a fetch by a late mem_req
        vecs[28] = mk(6'b110000, 5'b00000, 6'h07);
        vecs[29] = mk(6'b111000, 5'b10000, 6'h1F);
        vecs[30] = mk(6'b111001, 5'b10100, 6'h1F);
        vecs[31] = mk(6'b101001, 5'b11010, 6'h00);
        // idle ignores mc_done; idle flush
        vecs[32] = mk(6'b100001, 5'b00000, 6'h00);
        vecs[33] = mk(6'b100010, 5'b00001, 6'h00);
        // reset during MEM access, stray completion afterwards
        vecs[34] = mk(6'b101000, 5'b00000, 6'h1F);
        vecs[35] = mk(6'b101000, 5'b11000, 6'h1F);
        vecs[36] = mk(6'b001001, 5'b00000, 6'h00);
        vecs[37] = mk(6'b100001, 5'b00000, 6'h00);
        vecs[38] = mk(6'b100000, 5'b00000, 6'h00);

        for (int i = 0; i < c_NVEC; i++) begin
            step(vecs[i], i);
        end

        // reset asserted just after a clock edge must clear outputs at once
        step(mk(6'b101000, 5'b00000, 6'h1F), 100);
        step(mk(6'b101000, 5'b11000, 6'h1F), 101);
        @(posedge clk);
        #2;
        drive(mk(6'b001000, 5'b00000, 6'h00), 102);
        #1;
        sample();
        step(mk(6'b100001, 5'b00000, 6'h00), 103);
        step(mk(6'b100000, 5'b00000, 6'h00), 104);
        step(mk(6'b110000, 5'b00000, 6'h07), 105);
        step(mk(6'b110001, 5'b10100, 6'h00), 106);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
